// File: rtl/nibble_serial_adder_ctrl_pkg.sv
// Shared types and helpers for the nibble-serial adder controller.
package nibble_serial_adder_ctrl_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Number of nibble iterations needed for a given operand width.
  function automatic int calc_nibbles(input int width);
    return width / NIBBLE_W;
  endfunction

endpackage

// File: rtl/nibble_serial_adder_ctrl_adder4.sv
// Combinational 4-bit ripple-carry adder made of four full-adder cells.
module nibble_adder4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic [4:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < 4; i++) begin : g_fa
    assign sum[i]  = a[i] ^ b[i] ^ c[i];
    assign c[i+1]  = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
  end

  assign cout = c[4];

endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// Nibble-serial add/subtract controller: one 4-bit slice iterated LSB first.
//
// state | meaning
// IDLE  | waiting for an operand set, in_ready=1
// RUN   | one nibble added per cycle, idx selects the nibble
// DONE  | result held on sum/cout, out_valid=1 until out_ready
module nibble_serial_adder_ctrl
  import nibble_serial_adder_ctrl_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int NIBBLES = calc_nibbles(WIDTH);
  localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  if (((WIDTH % NIBBLE_W) != 0) || (WIDTH < 8)) begin : g_bad_width
    $error("nibble_serial_adder_ctrl: WIDTH must be a multiple of 4 and >= 8");
  end

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_r, b_r, sum_r;
  logic [IDX_W-1:0] idx;
  logic             carry;
  logic             cout_r;
  logic [3:0]       a_nib, b_nib, s_nib;
  logic             c_nib;

  assign a_nib = a_r[idx*NIBBLE_W +: NIBBLE_W];
  assign b_nib = b_r[idx*NIBBLE_W +: NIBBLE_W];

  nibble_adder4 u_slice (
    .a    (a_nib),
    .b    (b_nib),
    .cin  (carry),
    .sum  (s_nib),
    .cout (c_nib)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode; handshake outputs depend on state only.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = RUN;
      end
      RUN: begin
        if (idx == LAST_IDX) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture on acceptance, then one nibble written per RUN cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r    <= '0;
      b_r    <= '0;
      sum_r  <= '0;
      idx    <= '0;
      carry  <= 1'b0;
      cout_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_r    <= a;
            b_r    <= sub ? ~b : b;
            carry  <= sub ? 1'b1 : cin;
            idx    <= '0;
            sum_r  <= '0;
            cout_r <= 1'b0;
          end
        end
        RUN: begin
          sum_r[idx*NIBBLE_W +: NIBBLE_W] <= s_nib;
          carry <= c_nib;
          if (idx == LAST_IDX) begin
            cout_r <= c_nib;
            idx    <= '0;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign sum  = sum_r;
  assign cout = cout_r;

endmodule
